// File: rtl/vai_tx_arbiter.sv
// vai_tx_arbiter: round-robin c1 Tx arbiter with burst locking and vmid tagging.
// Define VAI_TX_ARB_STATS_EN to add per-requester grant_count counters.
module vai_tx_arbiter #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int DATA_WIDTH = 600,
  parameter int VMID_WIDTH = $clog2(NUM_SUB_AFUS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SUB_AFUS-1:0]            req_valid,
  input  logic [NUM_SUB_AFUS-1:0]            req_sop,
  input  logic [2*NUM_SUB_AFUS-1:0]          req_len,
  input  logic [DATA_WIDTH*NUM_SUB_AFUS-1:0] req_data,
  output logic [NUM_SUB_AFUS-1:0]            req_ready,
  input  logic [NUM_SUB_AFUS-1:0]            disable_mask,
  input  logic                               out_almfull,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [VMID_WIDTH-1:0]              out_vmid,
  output logic                               busy,
  output logic                               proto_err,
  output logic                               abort_err
`ifdef VAI_TX_ARB_STATS_EN
  ,
  output logic [32*NUM_SUB_AFUS-1:0]         grant_count
`endif
);
  localparam int N = NUM_SUB_AFUS;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [VMID_WIDTH-1:0] rr_ptr, rr_n, owner, owner_n, sel, win, stray;
  logic [1:0] beats_left, beats_n, win_len;
  logic [N-1:0] elig, strays;
  logic has_win, has_stray, hold, acc, drop, sop_acc, set_proto, set_abort;
  assign hold = out_almfull | reset;
  assign elig = req_valid & req_sop & ~disable_mask;
  assign strays = req_valid & ~req_sop & ~disable_mask;
  assign win_len = req_len[2*win +: 2];
  assign busy = state == LOCKED;
  assign req_ready = {{(N-1){1'b0}}, acc} << sel;
  // Descending scans with overwrite leave the nearest hit: from rr_ptr for sop, from 0 for strays.
  always_comb begin
    win = rr_ptr;
    has_win = 1'b0;
    stray = '0;
    has_stray = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[rr_ptr + VMID_WIDTH'(k)]) begin
        win = rr_ptr + VMID_WIDTH'(k);
        has_win = 1'b1;
      end
      if (strays[k]) begin
        stray = VMID_WIDTH'(k);
        has_stray = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    beats_n = beats_left;
    rr_n = rr_ptr;
    sel = owner;
    acc = 1'b0;
    drop = 1'b0;
    sop_acc = 1'b0;
    set_proto = 1'b0;
    set_abort = 1'b0;
    if (state == IDLE) begin
      sel = has_win ? win : stray;
      acc = !hold && (has_win || has_stray);
      drop = acc && !has_win;
      sop_acc = acc && has_win;
      set_proto = drop || (sop_acc && win_len == 2'd2);
      if (sop_acc) begin
        rr_n = win + 1'b1;
        if (win_len[0]) begin
          state_n = LOCKED;
          owner_n = win;
          beats_n = win_len;
        end
      end
    end else if (disable_mask[owner]) begin
      state_n = IDLE;
      beats_n = '0;
      set_abort = 1'b1;
    end else if (req_valid[owner] && req_sop[owner]) begin
      set_proto = 1'b1;
    end else if (req_valid[owner] && !hold) begin
      acc = 1'b1;
      beats_n = beats_left - 1'b1;
      state_n = beats_left == 2'd1 ? IDLE : LOCKED;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beats_left <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_vmid <= '0;
      proto_err <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      owner <= owner_n;
      beats_left <= beats_n;
      out_valid <= acc && !drop;
      if (acc && !drop) begin
        out_data <= req_data[DATA_WIDTH*sel +: DATA_WIDTH];
        out_vmid <= sel;
      end
      proto_err <= proto_err | set_proto;
      abort_err <= abort_err | set_abort;
    end
  end
`ifdef VAI_TX_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic [31:0] cnt;
    assign grant_count[32*i +: 32] = cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (disable_mask[i]) cnt <= '0;
      else if (sop_acc && win == VMID_WIDTH'(i)) cnt <= cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vai_tx_arbiter.sv
// tb_vai_tx_arbiter: directed scoreboard bench for vai_tx_arbiter (default build).
module tb_vai_tx_arbiter;
  localparam int N = 8;
  localparam int DW = 600;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_sop = '0, disable_mask = '0, req_ready;
  logic [2*N-1:0] req_len = '0;
  logic [DW*N-1:0] req_data = '0;
  logic out_almfull = 1'b0, out_valid, busy, proto_err, abort_err;
  logic [DW-1:0] out_data;
  logic [2:0] out_vmid;
  int total = 0, bad = 0, cyc = 0, tag = 1;
  typedef struct {
    logic [2:0] vmid;
    logic [DW-1:0] data;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t cur;

  vai_tx_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sop(req_sop),
    .req_len(req_len), .req_data(req_data), .req_ready(req_ready),
    .disable_mask(disable_mask), .out_almfull(out_almfull), .out_valid(out_valid),
    .out_data(out_data), .out_vmid(out_vmid), .busy(busy),
    .proto_err(proto_err), .abort_err(abort_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag_s, got, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit sop, input logic [1:0] len);
    req_valid[i] = v;
    req_sop[i] = sop;
    req_len[2*i +: 2] = len;
    req_data[DW*i +: DW] = DW'({8'(i), 24'(tag)});
    tag++;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_sop = '0;
    req_len = '0;
  endtask

  // Called just after a falling edge with inputs set; checks ready, queues the expected beat.
  task automatic step(input logic [N-1:0] er, input bit drop);
    int idx;
    idx = 0;
    #1;
    chk("req_ready", req_ready, er);
    for (int i = 0; i < N; i++) if (er[i]) idx = i;
    if (er != '0 && !drop) q.push_back('{3'(idx), req_data[DW*idx +: DW], cyc});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL beat_unexpected got_vmid=%0d exp=none", out_vmid);
      end
      if (q.size() != 0) begin
        cur = q.pop_front();
        chk("out_vmid", 64'(out_vmid), 64'(cur.vmid));
        chk("latency", 64'(cyc), 64'(cur.cyc + 1));
        total++;
        assert (out_data === cur.data) else begin
          bad++;
          $error("FAIL out_data got=%0h exp=%0h", out_data[31:0], cur.data[31:0]);
        end
      end
    end
  end

  initial begin
    int order[3];
    order = '{0, 3, 5};
    set_req(0, 1, 1, 0);
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_abort", abort_err, 0);
    chk("rst_vmid", out_vmid, 0);
    @(negedge clk);
    reset = 1'b0;
    clr_all();
    // fairness among 0,3,5
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1, 1, 0);
      set_req(3, 1, 1, 0);
      set_req(5, 1, 1, 0);
      step(N'(1) << order[k % 3], 0);
    end
    clr_all();
    set_req(1, 1, 1, 0);
    step(N'(1) << 1, 0);
    // 4CL burst from 2 with 1 waiting
    set_req(2, 1, 1, 3);
    set_req(1, 1, 1, 0);
    step(N'(1) << 2, 0);
    chk("burst_busy1", busy, 1);
    for (int k = 0; k < 3; k++) begin
      set_req(2, 1, 0, 0);
      step(N'(1) << 2, 0);
      chk("burst_busy", busy, k < 2);
    end
    set_req(2, 0, 0, 0);
    step(N'(1) << 1, 0);
    clr_all();
    // back-pressure mid 2CL burst from 4
    set_req(4, 1, 1, 1);
    step(N'(1) << 4, 0);
    set_req(4, 1, 0, 0);
    set_req(0, 1, 1, 0);
    out_almfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step('0, 0);
      chk("stall_busy", busy, 1);
    end
    out_almfull = 1'b0;
    step(N'(1) << 4, 0);
    chk("bp_busy_done", busy, 0);
    set_req(4, 0, 0, 0);
    step(N'(1) << 0, 0);
    clr_all();
    // disabled requester 6
    disable_mask[6] = 1'b1;
    set_req(6, 1, 1, 0);
    set_req(7, 1, 1, 0);
    step(N'(1) << 7, 0);
    set_req(7, 0, 0, 0);
    step('0, 0);
    step('0, 0);
    clr_all();
    // abort: owner 3 disabled after beat 1
    set_req(3, 1, 1, 3);
    step(N'(1) << 3, 0);
    chk("abort_busy_pre", busy, 1);
    disable_mask[3] = 1'b1;
    set_req(3, 1, 0, 0);
    step('0, 0);
    chk("abort_err", abort_err, 1);
    chk("abort_busy", busy, 0);
    step('0, 0);
    chk("abort_proto", proto_err, 0);
    disable_mask = '0;
    clr_all();
    // protocol errors
    set_req(7, 1, 0, 0);
    step(N'(1) << 7, 1);
    chk("stray_proto", proto_err, 1);
    clr_all();
    set_req(0, 1, 1, 2);
    step(N'(1) << 0, 0);
    chk("len2_busy", busy, 0);
    chk("len2_proto", proto_err, 1);
    clr_all();
    // async reset mid-burst
    set_req(5, 1, 1, 1);
    step(N'(1) << 5, 0);
    chk("rst_mid_busy_pre", busy, 1);
    set_req(5, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_proto", proto_err, 0);
    chk("arst_abort", abort_err, 0);
    chk("arst_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    clr_all();
    set_req(7, 1, 1, 0);
    set_req(1, 1, 1, 0);
    step(N'(1) << 1, 0);
    clr_all();
    step('0, 0);
    step('0, 0);
    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vai_tx_arbiter.md
Name: vai_tx_arbiter

Overview:
- Round-robin arbiter that shares one CCI-P write-request Tx channel (c1) among NUM_SUB_AFUS sub-AFU requesters.
- Sits between the sub-AFU Tx ports and the manager's c1 Tx FIFO input.
- Keeps multi-CL write bursts contiguous and tags each output beat with the source vmid.
- Honours upstream almost-full back-pressure and the manager's per-sub-AFU reset mask.

Parameters:
- NUM_SUB_AFUS, 8, number of requesters; power of two, 2..32.
- DATA_WIDTH, 600, width of one request beat (hdr+data).
- VMID_WIDTH, $clog2(NUM_SUB_AFUS), width of the source tag.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_SUB_AFUS  per-requester beat valid.
- req_sop  in  NUM_SUB_AFUS  beat is the first beat of a burst.
- req_len  in  2*NUM_SUB_AFUS  burst length code on the sop beat: 0=1CL, 1=2CL, 3=4CL; 2 is illegal.
- req_data  in  DATA_WIDTH*NUM_SUB_AFUS  per-requester beat payload.
- req_ready  out  NUM_SUB_AFUS  combinational accept; a beat transfers when valid&&ready.
- disable_mask  in  NUM_SUB_AFUS  bit i=1 means sub-AFU i is held in reset (low bits of sub_afu_reset).
- out_almfull  in  1  downstream almost-full.
- out_valid  out  1  registered output beat valid.
- out_data  out  DATA_WIDTH  registered output payload.
- out_vmid  out  VMID_WIDTH  registered source requester index.
- busy  out  1  high while a multi-CL burst is in progress.
- proto_err  out  1  sticky protocol-error flag.
- abort_err  out  1  sticky burst-aborted flag.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, beats_left=0. out_valid, out_data, out_vmid, busy, proto_err and abort_err all 0.
- req_ready is all-zero whenever out_almfull=1 or reset=1.
- Eligibility in IDLE: requester i is eligible when req_valid[i] && req_sop[i] && !disable_mask[i].
- IDLE grant:
  - The winner is the first eligible requester scanning upward from rr_ptr, modulo NUM_SUB_AFUS.
  - req_ready is set for the winner only, in the same cycle; the beat is accepted that cycle.
  - On accept: rr_ptr <= winner+1, wrapping modulo N.
  - If req_len is 1 or 3, go to LOCKED with owner=winner and beats_left=req_len (1 or 3).
  - If req_len is 0, stay in IDLE.
- Illegal length: req_len=2 on a sop beat is accepted as 1CL, stays in IDLE and sets proto_err.
- Stray non-sop beat in IDLE:
  - Applies to a requester with req_valid=1, req_sop=0, not disabled.
  - Handled only when no eligible sop beat exists this cycle; lowest index wins.
  - The beat is accepted (ready=1) and dropped: no out_valid. proto_err is set.
- LOCKED state:
  - Only the owner may get req_ready.
  - A beat with req_sop=0 is accepted and decrements beats_left. When beats_left reaches 0 on an accept, go to IDLE.
  - A sop beat from the owner while LOCKED is not accepted (ready=0) and sets proto_err. The arbiter stays LOCKED.
  - Other requesters are not served; gaps from the owner are allowed.
- Owner disabled mid-burst: disable_mask[owner]=1 in LOCKED forces IDLE next cycle, sets abort_err and emits no further beats for that burst. Arbitration may grant in the first IDLE cycle after that.
- busy = (state==LOCKED).
- Output latency is exactly 1 cycle:
  - out_valid <= accepted && !dropped.
  - out_data and out_vmid are registered from the accepted beat.
  - out_data/out_vmid hold their value when out_valid=0.
- rr_ptr advances only on sop accepts, never on continuation beats or drops.
- Sticky flags clear only on reset.
- Async reset mid-burst: returns immediately to reset values; any partial burst is lost.

Optional Feature:
- VAI_TX_ARB_STATS_EN defined:
  - Adds output grant_count, 32*NUM_SUB_AFUS bits wide: per-requester 32-bit counters of accepted sop beats.
  - Counters wrap at 2^32 and reset to 0.
  - Each counter also clears when its disable_mask bit is 1.
- VAI_TX_ARB_STATS_EN undefined: grant_count port is absent and no counter logic is built.

Test Plan:
- Fairness: requesters 0, 3 and 5 hold continuous 1CL sop beats, mask=0 → out_vmid sequence is 0,3,5,0,3,5…; each beat appears one cycle after its accept.
- Burst contiguity: req 2 sends a 4CL burst (len=3) while req 1 is valid with 1CL → four consecutive vmid=2 beats, then vmid=1; busy=1 for exactly the cycles after the first accept until the 4th accept.
- Back-pressure: out_almfull=1 for 5 cycles in the middle of a 2CL burst from req 4 → req_ready all 0 and no out_valid during the stall; the burst resumes from beat 2 afterwards; no other vmid is interleaved.
- Disabled requester and mid-burst abort:
  - disable_mask[6]=1 with req 6 valid → never granted.
  - Set disable_mask[owner]=1 after beat 1 of a 4CL burst → abort_err=1, busy=0 next cycle, no further beats from the owner.
- Protocol errors: non-sop beat in IDLE from req 7 → dropped and proto_err=1; sop with len=2 → one beat output and proto_err remains 1.
- Reset mid-burst: assert reset asynchronously during LOCKED → out_valid, busy and flags are 0 immediately; after release, the first grant starts from index 0.
